sonata_reg_master: RTL and testbench

- Register-bus initiator. Converts a framed host byte stream (UART or JTAG bridge) into reg_address/reg_bytecnt/reg_read/reg_write/reg_addrvalid transactions on the usb_clk register bus.
- Drives sonata_reg-style responders, which present registered read_data one cycle after reg_read.
- Returns read bytes, and optionally a write acknowledge, on an output byte stream.

---
 rtl/sonata_reg_master_if.sv | 36 +++
 rtl/sonata_reg_master.sv | 191 +++++++++++++++++++
 tb/tb_sonata_reg_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sonata_reg_master_if.sv
// Stream and register-bus signal bundle for sonata_reg_master.
// The master modport is the initiator's view and the slave modport is the view of
// everything around it: host stream source, response sink and register responders.
interface sonata_reg_master_if #(
  parameter int pBYTECNT_SIZE = 7
) ();
  logic [7:0]               s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [7:0]               m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     abort;
  logic                     busy;
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               write_data;
  logic [7:0]               read_data;
  logic                     reg_read;
  logic                     reg_write;
  logic                     reg_addrvalid;

  modport master (
    input  s_data, s_valid, m_ready, abort, read_data,
    output s_ready, m_data, m_valid, busy,
           reg_address, reg_bytecnt, write_data,
           reg_read, reg_write, reg_addrvalid
  );

  modport slave (
    output s_data, s_valid, m_ready, abort, read_data,
    input  s_ready, m_data, m_valid, busy,
           reg_address, reg_bytecnt, write_data,
           reg_read, reg_write, reg_addrvalid
  );
endinterface

// File: rtl/sonata_reg_master.sv
// Register-bus initiator. It parses a framed host byte stream into register-bus
// read and write transactions, and it returns read bytes and an optional write
// acknowledge byte on the response stream.
// Frame layout: {rw, len_m1[6:0]}, then the address, then len_m1+1 data bytes for writes.
module sonata_reg_master #(
  parameter int         pBYTECNT_SIZE = 7,
  parameter int         pREAD_LATENCY = 1,
  parameter bit         pACK_EN       = 1'b1,
  parameter logic [7:0] pWRITE_ACK    = 8'hA5
) (
  input logic                 usb_clk,
  input logic                 reset_i,
  sonata_reg_master_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WSTB, S_RSTB, S_RWAIT, S_ROUT, S_ACK, S_DONE
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_rw, w_rw_nxt;
  logic [6:0]               r_len_m1, w_len_m1_nxt;
  logic [6:0]               r_idx, w_idx_nxt;
  logic [1:0]               r_lat, w_lat_nxt;
  logic [7:0]               r_reg_address, w_reg_address_nxt;
  logic [pBYTECNT_SIZE-1:0] r_reg_bytecnt, w_reg_bytecnt_nxt;
  logic [7:0]               r_write_data, w_write_data_nxt;
  logic                     r_reg_read, w_reg_read_nxt;
  logic                     r_reg_write, w_reg_write_nxt;
  logic                     r_reg_addrvalid, w_reg_addrvalid_nxt;
  logic [7:0]               r_m_data, w_m_data_nxt;
  logic                     r_m_valid, w_m_valid_nxt;
  logic                     r_s_ready, w_s_ready_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     w_accept, w_last, w_abort;

  assign w_accept = bus.s_valid & r_s_ready;
  assign w_last   = (r_idx == r_len_m1);
  assign w_abort  = bus.abort & (r_state != S_IDLE);

  // Next-state and next-output logic. Every output is registered, so the values
  // computed here appear on the bus in the cycle after the decision is made.
  always_comb begin
    w_state_nxt         = r_state;
    w_rw_nxt            = r_rw;
    w_len_m1_nxt        = r_len_m1;
    w_idx_nxt           = r_idx;
    w_lat_nxt           = r_lat;
    w_reg_address_nxt   = r_reg_address;
    w_reg_bytecnt_nxt   = r_reg_bytecnt;
    w_write_data_nxt    = r_write_data;
    w_reg_read_nxt      = 1'b0;
    w_reg_write_nxt     = 1'b0;
    w_reg_addrvalid_nxt = r_reg_addrvalid;
    w_m_data_nxt        = r_m_data;
    w_m_valid_nxt       = r_m_valid;

    case (r_state)
      S_IDLE: if (w_accept) begin
        w_rw_nxt     = bus.s_data[7];
        w_len_m1_nxt = bus.s_data[6:0];
        w_state_nxt  = S_ADDR;
      end
      S_ADDR: if (w_accept) begin
        w_reg_address_nxt   = bus.s_data;
        w_reg_bytecnt_nxt   = '0;
        w_reg_addrvalid_nxt = 1'b1;
        w_idx_nxt           = '0;
        w_state_nxt         = r_rw ? S_RSTB : S_WDATA;
      end
      S_WDATA: if (w_accept) begin
        w_write_data_nxt  = bus.s_data;
        w_reg_bytecnt_nxt = r_idx[pBYTECNT_SIZE-1:0];
        w_reg_write_nxt   = 1'b1;
        w_state_nxt       = S_WSTB;
      end
      // The reg_write strobe is high during this state. The stream is stalled here,
      // so consecutive writes always have at least one idle strobe cycle between them.
      S_WSTB: begin
        if (w_last) begin
          if (pACK_EN) begin
            w_m_data_nxt  = pWRITE_ACK;
            w_m_valid_nxt = 1'b1;
            w_state_nxt   = S_ACK;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_idx_nxt   = r_idx + 7'd1;
          w_state_nxt = S_WDATA;
        end
      end
      S_RSTB: begin
        w_reg_bytecnt_nxt = r_idx[pBYTECNT_SIZE-1:0];
        w_reg_read_nxt    = 1'b1;
        w_lat_nxt         = '0;
        w_state_nxt       = S_RWAIT;
      end
      // The first RWAIT cycle is the reg_read cycle (r_lat == 0). read_data is
      // captured once pREAD_LATENCY cycles have elapsed after that cycle.
      S_RWAIT: begin
        if (r_lat == 2'(pREAD_LATENCY)) begin
          w_m_data_nxt  = bus.read_data;
          w_m_valid_nxt = 1'b1;
          w_state_nxt   = S_ROUT;
        end else begin
          w_lat_nxt = r_lat + 2'd1;
        end
      end
      S_ROUT: if (bus.m_ready) begin
        w_m_valid_nxt = 1'b0;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 7'd1;
          w_state_nxt = S_RSTB;
        end
      end
      S_ACK: if (bus.m_ready) begin
        w_m_valid_nxt = 1'b0;
        w_state_nxt   = S_DONE;
      end
      S_DONE: begin
        w_reg_addrvalid_nxt = 1'b0;
        w_reg_bytecnt_nxt   = '0;
        w_state_nxt         = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_abort) begin
      w_state_nxt         = S_IDLE;
      w_reg_addrvalid_nxt = 1'b0;
      w_reg_read_nxt      = 1'b0;
      w_reg_write_nxt     = 1'b0;
      w_m_valid_nxt       = 1'b0;
    end

    w_s_ready_nxt = !w_abort && (w_state_nxt inside {S_IDLE, S_ADDR, S_WDATA});
    w_busy_nxt    = (w_state_nxt != S_IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) begin
      r_state         <= S_IDLE;
      r_rw            <= 1'b0;
      r_len_m1        <= '0;
      r_idx           <= '0;
      r_lat           <= '0;
      r_reg_address   <= '0;
      r_reg_bytecnt   <= '0;
      r_write_data    <= '0;
      r_reg_read      <= 1'b0;
      r_reg_write     <= 1'b0;
      r_reg_addrvalid <= 1'b0;
      r_m_data        <= '0;
      r_m_valid       <= 1'b0;
      r_s_ready       <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_rw            <= w_rw_nxt;
      r_len_m1        <= w_len_m1_nxt;
      r_idx           <= w_idx_nxt;
      r_lat           <= w_lat_nxt;
      r_reg_address   <= w_reg_address_nxt;
      r_reg_bytecnt   <= w_reg_bytecnt_nxt;
      r_write_data    <= w_write_data_nxt;
      r_reg_read      <= w_reg_read_nxt;
      r_reg_write     <= w_reg_write_nxt;
      r_reg_addrvalid <= w_reg_addrvalid_nxt;
      r_m_data        <= w_m_data_nxt;
      r_m_valid       <= w_m_valid_nxt;
      r_s_ready       <= w_s_ready_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  assign bus.s_ready       = r_s_ready;
  assign bus.m_data        = r_m_data;
  assign bus.m_valid       = r_m_valid;
  assign bus.busy          = r_busy;
  assign bus.reg_address   = r_reg_address;
  assign bus.reg_bytecnt   = r_reg_bytecnt;
  assign bus.write_data    = r_write_data;
  assign bus.reg_read      = r_reg_read;
  assign bus.reg_write     = r_reg_write;
  assign bus.reg_addrvalid = r_reg_addrvalid;

endmodule

// File: tb/tb_sonata_reg_master.sv
// Bench for sonata_reg_master: directed frames, a register responder model, and a
// queue-based scoreboard that is checked by an independent negedge monitor.
module tb_sonata_reg_master;

  logic usb_clk = 1'b0;
  logic reset_i;

  sonata_reg_master_if #(.pBYTECNT_SIZE(7)) bus ();

  sonata_reg_master #(
    .pBYTECNT_SIZE(7),
    .pREAD_LATENCY(1),
    .pACK_EN(1'b1),
    .pWRITE_ACK(8'hA5)
  ) dut (
    .usb_clk(usb_clk),
    .reset_i(reset_i),
    .bus(bus)
  );

  always #5 usb_clk = ~usb_clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [6:0] cnt;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_w[$];
  logic [7:0] exp_m[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_rd = 0;
  int         n_wr = 0;
  int         n_mhs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: registered read data (0x10 + bytecnt), one cycle after reg_read.
  always @(posedge usb_clk or posedge reset_i) begin
    if (reset_i) bus.read_data <= 8'h00;
    else if (bus.reg_read) bus.read_data <= 8'h10 + 8'(bus.reg_bytecnt);
  end

  // Monitor: checks bus rules and pops the scoreboard on every strobe or handshake.
  always @(negedge usb_clk) begin
    if (bus.reg_read || bus.reg_write) begin
      chk("strobe_addrvalid", 32'(bus.reg_addrvalid), 32'd1);
      chk("rw_exclusive", 32'(bus.reg_read & bus.reg_write), 32'd0);
    end
    if (bus.reg_read) n_rd++;
    if (bus.reg_write) begin
      wr_t w;
      n_wr++;
      chk("write_expected", 32'(exp_w.size() != 0), 32'd1);
      if (exp_w.size() != 0) begin
        w = exp_w.pop_front();
        chk("wr_addr", 32'(bus.reg_address), 32'(w.addr));
        chk("wr_bytecnt", 32'(bus.reg_bytecnt), 32'(w.cnt));
        chk("wr_data", 32'(bus.write_data), 32'(w.data));
      end
    end
    if (bus.m_valid && bus.m_ready) begin
      n_mhs++;
      chk("mbyte_expected", 32'(exp_m.size() != 0), 32'd1);
      if (exp_m.size() != 0) chk("m_data", 32'(bus.m_data), 32'(exp_m.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    @(negedge usb_clk);
    while (!bus.s_ready && n < 100) begin
      @(negedge usb_clk);
      n++;
    end
    if (n >= 100) chk("s_ready_timeout", 32'(bus.s_ready), 32'd1);
    @(posedge usb_clk);
    #1 bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_w.size() != 0 || exp_m.size() != 0) && n < 500) begin
      @(negedge usb_clk);
      n++;
    end
    chk("drain_pending", 32'(exp_w.size() + exp_m.size()), 32'd0);
    repeat (3) @(posedge usb_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    chk({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_reg_address"}, 32'(bus.reg_address), 32'd0);
    chk({tag, "_reg_bytecnt"}, 32'(bus.reg_bytecnt), 32'd0);
    chk({tag, "_write_data"}, 32'(bus.write_data), 32'd0);
    chk({tag, "_reg_read"}, 32'(bus.reg_read), 32'd0);
    chk({tag, "_reg_write"}, 32'(bus.reg_write), 32'd0);
    chk({tag, "_addrvalid"}, 32'(bus.reg_addrvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    reset_i     = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.m_ready = 1'b1;
    bus.abort   = 1'b0;
    #12 check_zero("reset");
    @(posedge usb_clk);
    #1 reset_i = 1'b0;

    // Single-byte write with ack.
    exp_w.push_back(wr_t'{8'h05, 7'd0, 8'h3C});
    exp_m.push_back(8'hA5);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h3C);
    drain();
    chk("w1_addrvalid_after", 32'(bus.reg_addrvalid), 32'd0);
    chk("w1_busy_after", 32'(bus.busy), 32'd0);

    // 16-byte write.
    base = n_wr;
    for (int i = 0; i < 16; i++) exp_w.push_back(wr_t'{8'h0A, 7'(i), 8'(i)});
    exp_m.push_back(8'hA5);
    send_byte(8'h0F); send_byte(8'h0A);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    drain();
    chk("w16_count", 32'(n_wr - base), 32'd16);
    chk("w16_addrvalid_after", 32'(bus.reg_addrvalid), 32'd0);

    // 4-byte read, m_ready high.
    base = n_rd;
    for (int i = 0; i < 4; i++) exp_m.push_back(8'h10 + 8'(i));
    send_byte(8'h83); send_byte(8'h20);
    drain();
    chk("r4_read_pulses", 32'(n_rd - base), 32'd4);
    chk("r4_addrvalid_after", 32'(bus.reg_addrvalid), 32'd0);

    // 4-byte read with the sink stalled on the first byte.
    base = n_rd;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_m.push_back(8'h10 + 8'(i));
    send_byte(8'h83); send_byte(8'h20);
    n = 0;
    while (!bus.m_valid && n < 50) begin
      @(negedge usb_clk);
      n++;
    end
    chk("stall_m_valid_seen", 32'(bus.m_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge usb_clk);
      chk("stall_m_valid", 32'(bus.m_valid), 32'd1);
      chk("stall_m_data", 32'(bus.m_data), 32'h10);
      chk("stall_no_read", 32'(bus.reg_read), 32'd0);
    end
    @(posedge usb_clk);
    #1 bus.m_ready = 1'b1;
    drain();
    chk("stall_read_pulses", 32'(n_rd - base), 32'd4);

    // Asynchronous reset after the second byte of a read.
    base = n_mhs;
    for (int i = 0; i < 4; i++) exp_m.push_back(8'h10 + 8'(i));
    send_byte(8'h83); send_byte(8'h20);
    n = 0;
    while (n_mhs < base + 2 && n < 100) begin
      @(negedge usb_clk);
      n++;
    end
    chk("rst_two_bytes_seen", 32'(n_mhs - base), 32'd2);
    @(posedge usb_clk);
    #2 reset_i = 1'b1;
    #1 check_zero("midrst");
    exp_m.delete();
    @(posedge usb_clk);
    #1 reset_i = 1'b0;
    exp_w.push_back(wr_t'{8'h01, 7'd0, 8'h7E});
    exp_m.push_back(8'hA5);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h7E);
    drain();
    chk("rst_frame_busy_after", 32'(bus.busy), 32'd0);

    // Abort during a 4-byte write, after the second data byte.
    base = n_wr;
    exp_w.push_back(wr_t'{8'h30, 7'd0, 8'hB0});
    exp_w.push_back(wr_t'{8'h30, 7'd1, 8'hB1});
    send_byte(8'h03); send_byte(8'h30); send_byte(8'hB0); send_byte(8'hB1);
    bus.abort = 1'b1;
    @(posedge usb_clk);
    #1 bus.abort = 1'b0;
    @(negedge usb_clk);
    chk("abort_addrvalid", 32'(bus.reg_addrvalid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_reg_write", 32'(bus.reg_write), 32'd0);
    chk("abort_m_valid", 32'(bus.m_valid), 32'd0);
    repeat (6) @(negedge usb_clk);
    chk("abort_write_pulses", 32'(n_wr - base), 32'd2);
    chk("abort_no_ack", 32'(bus.m_valid), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
